// File: rtl/spi_pkg.sv
// Shared types for the SPI master frame generator: FSM states, the
// {CPOL,CPHA} mode pair and the four standard mode constants.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRONT = 2'd1,
        ST_SHIFT = 2'd2,
        ST_BACK  = 2'd3
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } mode_t;

    localparam mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: counts half-periods of H clk cycles, drives SCLK and
// reports whether the edge produced on a tick is leading or trailing.
module spi_sclk_gen #(
    parameter int DIV_LOG2 = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic cpol,
    input  logic run,
    input  logic edge_en,
    output logic sclk,
    output logic tick,
    output logic pre_tick,
    output logic lead,
    output logic trail
);

    localparam int CW = DIV_LOG2 - 1;
    localparam int HALF = 1 << CW;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] PRE  = CW'(HALF - 2);

    logic [CW-1:0] cnt;
    logic          cpol_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sclk   <= 1'b0;
            cpol_q <= 1'b0;
        end else if (start) begin
            cnt    <= '0;
            sclk   <= cpol;
            cpol_q <= cpol;
        end else if (run) begin
            cnt <= cnt + CW'(1);
            if (tick && edge_en) begin
                sclk <= ~sclk;
            end
        end
    end

    assign tick     = run && (cnt == LAST);
    assign pre_tick = run && (cnt == PRE);
    // An edge leaving the idle level is the leading edge of a bit cell.
    assign lead  = tick && edge_en && (sclk == cpol_q);
    assign trail = tick && edge_en && (sclk != cpol_q);

endmodule

// File: rtl/spi_mnrch_gen.sv
// SPI master: one frame per accepted request, FRONT/SHIFT/BACK phases of
// H clk cycles each, MSB-first transmit and right-aligned receive.
module spi_mnrch_gen
    import spi_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DIV_LOG2 = 5,
    parameter int NUM_SS   = 2
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         snd,
    input  logic [WIDTH-1:0]                             cmd,
    input  logic [$clog2(WIDTH+1)-1:0]                   len,
    input  logic [1:0]                                   mode,
    input  logic [((NUM_SS > 1) ? $clog2(NUM_SS) : 1)-1:0] ss_sel,
    input  logic                                         MISO,
    output logic [NUM_SS-1:0]                            SS_n,
    output logic                                         SCLK,
    output logic                                         MOSI,
    output logic                                         busy,
    output logic                                         done,
    output logic [WIDTH-1:0]                             resp,
    output logic [1:0]                                   dbg_state
);

    localparam int LW = $clog2(WIDTH + 1);
    localparam int SW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
    localparam int EW = $clog2(2 * WIDTH + 1);

    state_t            state, state_n;
    mode_t             mode_in;
    logic              cpha_q;
    logic [LW-1:0]     len_q, len_eff, bit_cnt;
    logic [EW-1:0]     edge_cnt, two_len;
    logic [WIDTH-1:0]  tx_sr, rx_sr;
    logic [NUM_SS-1:0] ss_dec;
    logic              sample_pend;
    logic              accept, edge_req;
    logic              tick, pre_tick, lead, trail;
    logic              samp_edge, mosi_adv;

    assign mode_in   = mode;
    assign len_eff   = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;
    assign two_len   = EW'({len_q, 1'b0});
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    always_comb begin
        ss_dec = '0;
        for (int i = 0; i < NUM_SS; i++) begin
            if (ss_sel == SW'(i)) begin
                ss_dec[i] = 1'b1;
            end
        end
    end

    spi_sclk_gen #(.DIV_LOG2(DIV_LOG2)) u_sclk (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .cpol     (mode_in.cpol),
        .run      (busy),
        .edge_en  (edge_req),
        .sclk     (SCLK),
        .tick     (tick),
        .pre_tick (pre_tick),
        .lead     (lead),
        .trail    (trail)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        edge_req = 1'b0;
        case (state)
            ST_IDLE: begin
                if (snd) begin
                    accept  = 1'b1;
                    state_n = ST_FRONT;
                end
            end
            ST_FRONT: begin
                edge_req = 1'b1;
                if (tick) begin
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                edge_req = (edge_cnt < two_len);
                if (tick && (edge_cnt == two_len) && (bit_cnt == len_q)) begin
                    state_n = ST_BACK;
                end
            end
            ST_BACK: begin
                if (tick) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // CPHA=0 keeps the last bit on MOSI through the final trailing edge.
    assign samp_edge = cpha_q ? trail : lead;
    assign mosi_adv  = cpha_q ? lead
                              : (trail && (edge_cnt != (two_len - EW'(1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpha_q      <= 1'b0;
            len_q       <= '0;
            bit_cnt     <= '0;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            sample_pend <= 1'b0;
            SS_n        <= '1;
            MOSI        <= 1'b0;
            done        <= 1'b0;
            resp        <= '0;
        end else begin
            done <= (state == ST_BACK) && pre_tick;
            if (accept) begin
                cpha_q      <= mode_in.cpha;
                len_q       <= len_eff;
                bit_cnt     <= '0;
                edge_cnt    <= '0;
                tx_sr       <= mode_in.cpha ? cmd : (cmd << 1);
                rx_sr       <= '0;
                sample_pend <= 1'b0;
                SS_n        <= ~ss_dec;
                MOSI        <= cmd[WIDTH-1];
            end else begin
                sample_pend <= samp_edge;
                if (lead || trail) begin
                    edge_cnt <= edge_cnt + EW'(1);
                end
                if (mosi_adv) begin
                    MOSI  <= tx_sr[WIDTH-1];
                    tx_sr <= tx_sr << 1;
                end
                // MISO is taken one clk after the sampling edge reaches SCLK.
                if (sample_pend) begin
                    rx_sr   <= {rx_sr[WIDTH-2:0], MISO};
                    bit_cnt <= bit_cnt + LW'(1);
                end
                if ((state == ST_BACK) && pre_tick) begin
                    resp <= rx_sr;
                end
                if ((state == ST_BACK) && tick) begin
                    SS_n <= '1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mnrch_gen.sv
// Bench for spi_mnrch_gen: driver issues frames, a slave model answers on
// SCLK, and a monitor checks every done against the expected queue.
module tb_spi_mnrch_gen;

    localparam int W  = 16;
    localparam int DL = 5;
    localparam int NS = 3;
    localparam int H  = 1 << (DL - 1);
    localparam int LW = $clog2(W + 1);
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          snd = 1'b0;
    logic          MISO = 1'b0;
    logic [W-1:0]  cmd = '0;
    logic [LW-1:0] len = '0;
    logic [1:0]    mode = '0;
    logic [SW-1:0] ss_sel = '0;
    logic [NS-1:0] SS_n;
    logic          SCLK, MOSI, busy, done;
    logic [W-1:0]  resp;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W-1:0] last_exp = '0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_mosi_q[$];
    logic [W-1:0] word_q[$];
    logic [1:0]   mode_q[$];
    int           len_q[$];
    int           sel_q[$];

    spi_mnrch_gen #(.WIDTH(W), .DIV_LOG2(DL), .NUM_SS(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .snd       (snd),
        .cmd       (cmd),
        .len       (len),
        .mode      (mode),
        .ss_sel    (ss_sel),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Queue one frame's expectations, then present it until the DUT takes it.
    task automatic run_frame(input logic [W-1:0] c, input int l, input logic [1:0] m,
                             input int s, input logic [W-1:0] wd, input bit hold);
        int eff;
        int n;
        logic [31:0] msk;
        eff = (l == 0 || l > W) ? W : l;
        msk = (32'd1 << eff) - 32'd1;
        mode_q.push_back(m);
        len_q.push_back(eff);
        sel_q.push_back(s);
        word_q.push_back(wd);
        exp_q.push_back(wd & msk[W-1:0]);
        exp_mosi_q.push_back(W'(c >> (W - eff)));
        last_exp = wd & msk[W-1:0];
        @(negedge clk);
        cmd = c;
        len = LW'(l);
        mode = m;
        ss_sel = SW'(s);
        snd = 1'b1;
        n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        while (!busy && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=%0d expected=<2000", n);
        end
        if (!hold) snd = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || mode_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL idle_timeout actual=%0d expected=<3000", n);
        end
    endtask

    // Monitor and slave model, sampled on the falling clk edge.
    initial begin
        logic prev_sclk, prev_busy, prev_done, prev_ss_high, active, is_lead;
        logic [1:0]    c_mode;
        logic [W-1:0]  c_word, c_exp, c_mosi;
        logic [NS-1:0] pat;
        logic [31:0]   mosi_acc;
        int c_len, c_sel, mi, edges, low_cyc, bad_cyc;
        prev_sclk = 1'b0; prev_busy = 1'b0; prev_done = 1'b0; prev_ss_high = 1'b1;
        active = 1'b0; c_mode = '0; c_word = '0; c_exp = '0; c_mosi = '0; pat = '1;
        mosi_acc = '0; c_len = 0; c_sel = 0; mi = 0; edges = 0; low_cyc = 0; bad_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0; prev_busy = 1'b0; prev_done = 1'b0;
                prev_sclk = SCLK; prev_ss_high = 1'b1;
                continue;
            end
            if (busy && !prev_busy) begin
                if (mode_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_start actual=unexpected expected=none");
                end else begin
                    c_mode = mode_q.pop_front(); c_len = len_q.pop_front();
                    c_sel = sel_q.pop_front(); c_word = word_q.pop_front();
                    c_exp = exp_q.pop_front(); c_mosi = exp_mosi_q.pop_front();
                    active = 1'b1; edges = 0; low_cyc = 0; bad_cyc = 0; mosi_acc = '0;
                    mi = c_len - 1;
                    pat = '1;
                    if (c_sel < NS) pat[c_sel] = 1'b0;
                    check("ss_gap", prev_ss_high, 1);
                    check("front_sclk", SCLK, c_mode[1]);
                    if (!c_mode[0]) MISO = c_word[mi];
                    prev_sclk = SCLK;
                end
            end
            if (active) begin
                if (SCLK != prev_sclk) begin
                    edges++;
                    is_lead = (prev_sclk == c_mode[1]);
                    if (!c_mode[0]) begin
                        if (is_lead) mosi_acc = {mosi_acc[30:0], MOSI};
                        else begin
                            mi--;
                            if (mi >= 0) MISO = c_word[mi];
                        end
                    end else begin
                        if (is_lead) begin
                            if (mi >= 0) MISO = c_word[mi];
                            mi--;
                        end else mosi_acc = {mosi_acc[30:0], MOSI};
                    end
                end
                if (SS_n == pat && pat != '1) low_cyc++;
                else if (SS_n != '1) bad_cyc++;
            end
            if (done) begin
                check("done_pulse", prev_done, 0);
                if (!active) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected actual=1 expected=0");
                end else begin
                    check("resp", resp, c_exp);
                    check("mosi_word", mosi_acc, c_mosi);
                    check("sclk_edges", edges, 2 * c_len);
                    check("ss_low_cycles", low_cyc, (c_sel < NS) ? (2 + 2 * c_len) * H : 0);
                    check("ss_other_low", bad_cyc, 0);
                    check("back_sclk", SCLK, c_mode[1]);
                    active = 1'b0;
                    done_cnt++;
                end
            end
            prev_sclk = SCLK;
            prev_busy = busy;
            prev_done = done;
            prev_ss_high = (SS_n == '1);
        end
    end

    initial begin
        int dc;
        repeat (3) @(negedge clk);
        check("rst_ss_n", SS_n, 3'b111);
        check("rst_sclk", SCLK, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_resp", resp, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(16'hA5C3, 0, 2'b00, 0, 16'h3C5A, 1'b0);
        run_frame(16'h8001, 16, 2'b11, 0, 16'hFFFF, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        check("sclk_idle_cpol1", SCLK, 1);
        run_frame(16'hC300, 8, 2'b00, 0, 16'h005A, 1'b0);
        run_frame(W'($urandom), 16, 2'b01, 1, W'($urandom), 1'b0);
        run_frame(W'($urandom), 12, 2'b10, 3, W'($urandom), 1'b0);
        run_frame(W'($urandom), 20, 2'b01, 2, W'($urandom), 1'b0);
        run_frame(W'($urandom), 4, 2'b11, 1, W'($urandom), 1'b0);
        for (int i = 0; i < 12; i++) begin
            run_frame(W'($urandom), $urandom_range(0, 31), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 3), W'($urandom), 1'b0);
        end
        wait_idle();

        for (int i = 0; i < 3; i++) begin
            run_frame(W'($urandom), $urandom_range(4, 16), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 2), W'($urandom), 1'b1);
        end
        run_frame(W'($urandom), 6, 2'b00, 0, W'($urandom), 1'b0);
        wait_idle();
        repeat (20) @(negedge clk);
        check("resp_hold", resp, last_exp);

        run_frame(16'h1234, 16, 2'b10, 1, 16'hBEEF, 1'b0);
        repeat (199) @(negedge clk);
        dc = done_cnt;
        rst = 1'b1;
        #1;
        check("abort_ss_n", SS_n, 3'b111);
        check("abort_sclk", SCLK, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_resp", resp, 0);
        check("abort_state", dbg_state, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (H * 4) @(negedge clk);
        check("abort_no_done", done_cnt, dc);
        run_frame(16'h6A6A, 16, 2'b00, 0, 16'h9C31, 1'b0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        checks++;
        errors++;
        $display("FAIL global_timeout actual=expired expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_mnrch_gen.md
SPI_MNRCH_GEN -- requirements
Module: spi_mnrch_gen

Interface
REQ-001 Parameter WIDTH, default 16, maximum frame length in bits (4..32).
REQ-002 Parameter DIV_LOG2, default 5; SCLK period = 2^DIV_LOG2 clk cycles, half-period H = 2^(DIV_LOG2-1) (DIV_LOG2 >= 2).
REQ-003 Parameter NUM_SS, default 2, number of slave-select lines (1..8).
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 snd  input  1  start request, sampled in IDLE only.
REQ-007 cmd  input  WIDTH  transmit word, MSB first; left-aligned when len < WIDTH.
REQ-008 len  input  $clog2(WIDTH+1)  frame length in bits; 0 or >WIDTH treated as WIDTH.
REQ-009 mode  input  2  {CPOL,CPHA} for the frame.
REQ-010 ss_sel  input  $clog2(NUM_SS) (min 1)  slave index; out-of-range selects none.
REQ-011 MISO  input  1  serial data from slave.
REQ-012 SS_n  output  NUM_SS  active-low selects.
REQ-013 SCLK  output  1  serial clock.
REQ-014 MOSI  output  1  serial data to slave.
REQ-015 busy  output  1  high from the cycle after snd acceptance until the done cycle inclusive.
REQ-016 done  output  1  single-cycle completion pulse.
REQ-017 resp  output  WIDTH  received word, right-aligned, upper bits zero when len < WIDTH.

Function
REQ-018 snd, cmd, len, mode and ss_sel SHALL be latched together in the cycle snd is high in IDLE; snd outside IDLE SHALL be ignored.
REQ-019 FSM states: IDLE, FRONT, SHIFT, BACK; any illegal encoding SHALL go to IDLE.
REQ-020 IDLE->FRONT on snd: selected SS_n low next cycle, SCLK = latched CPOL, MOSI = cmd MSB.
REQ-021 FRONT SHALL last exactly H cycles with SCLK = CPOL, then enter SHIFT.
REQ-022 SHIFT SHALL produce exactly 2*len SCLK edges, each H cycles apart, first edge at FRONT exit.
REQ-023 CPHA=0: MISO sampled on leading edges, MOSI advances on trailing edges; last trailing edge does not advance MOSI.
REQ-024 CPHA=1: MOSI advances on leading edges (first leading edge presents bit len-1), MISO sampled on trailing edges.
REQ-025 MISO SHALL be captured into the shift register in the clk cycle after the SCLK sampling edge appears on the output.
REQ-026 Bit counter SHALL count sample events and leave SHIFT after the len-th sample and final edge.
REQ-027 BACK SHALL hold SCLK = CPOL for H cycles, then the last cycle raises all SS_n, asserts done for one cycle, loads resp, returns to IDLE.
REQ-028 resp SHALL hold its value until the next done; done SHALL never be high two consecutive cycles.
REQ-029 snd high in the done cycle SHALL NOT be accepted; earliest acceptance is the following IDLE cycle.
REQ-030 Out-of-range ss_sel SHALL run the full frame with all SS_n high.

Reset
REQ-031 rst high SHALL immediately force: state IDLE, SS_n all ones, SCLK 0, MOSI 0, busy 0, done 0, resp 0, counters 0.
REQ-032 rst asserted mid-frame SHALL abort without a done pulse; first frame after release starts with FRONT.

Structure
REQ-033 Package spi_pkg SHALL hold the state enum, the mode typedef {CPOL,CPHA} and constants MODE0..MODE3.
REQ-034 Sub-module spi_sclk_gen (divider, edge-strobe generation: lead, trail) is natural; the FSM and shift datapath stay in spi_mnrch_gen.

Verification
REQ-035 Defaults, mode 0, ss_sel 0, cmd 0xA5C3, slave model returns 0x3C5A -> resp 0x3C5A, SS_n[0] low 544 cycles, one done pulse.
REQ-036 Mode 3, cmd 0x8001, MISO tied 1 -> SCLK idles 1, 16 rising samples, resp 0xFFFF, MOSI bit order 1,0..0,1.
REQ-037 len 8, cmd 0xC300, slave returns 0x5A -> exactly 16 SCLK edges, resp 0x005A.
REQ-038 Mode 1, ss_sel 1 -> only SS_n[1] toggles, MISO captured on falling edges, resp matches model.
REQ-039 rst asserted at cycle 200 of a frame -> SS_n 2'b11, SCLK 0, no done; next frame completes correctly.
REQ-040 snd held high continuously -> back-to-back frames, one done each, SS_n high at least one cycle between frames.
